// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Combinational grant selection: first requester found searching upward from
// ptr_i, wrapping at NPORTS-1. A constant zero pointer gives fixed priority.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    localparam int PW    = idx_w(NPORTS)
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic [NPORTS-1:0] gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (!found && req_i[(int'(ptr_i) + i) % NPORTS]) begin
                gnt_o[(int'(ptr_i) + i) % NPORTS] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Multi-port arbiter in front of an asynchronous SRAM (IDLE/SETUP/ACCESS/HOLD).
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int NPORTS   = 2,
    parameter int WAIT_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        wr,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS-1:0]        ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]        sram_dq_o,
    output logic                     sram_dq_oe,
    input  logic [DATA_W-1:0]        sram_dq_i,
    output logic                     sram_nce,
    output logic                     sram_noe,
    output logic                     sram_nwe
);

    localparam int PW = idx_w(NPORTS);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NPORTS-1:0]  gnt_q;
    logic [NPORTS-1:0]  ack_q;
    logic               wr_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  dq_o_q;
    logic               nce_q;
    logic               noe_q;
    logic               nwe_q;
    logic               dq_oe_q;

    logic [NPORTS-1:0]  gnt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gidx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wr;

    sram_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
        .req_i (req),
        .ptr_i (ptr),
        .gnt_o (gnt)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt[i]) gidx = PW'(i);
        end
    end

    assign sel_addr  = addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[int'(gidx)*DATA_W +: DATA_W];
    assign sel_wr    = wr[gidx];

`ifdef SRAM_ARB_RR_EN
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next search starts one past the port being granted now.
    always_comb begin
        ptr_d = (int'(gidx) == NPORTS - 1) ? '0 : gidx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (state_q == ST_IDLE && |req) begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_o_q  <= '0;
            nce_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    // Request fields are latched once here; later port changes are ignored.
                    if (|req) begin
                        state_q <= ST_SETUP;
                        gnt_q   <= gnt;
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        dq_o_q  <= sel_wdata;
                        nce_q   <= 1'b0;
                        dq_oe_q <= sel_wr;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    cnt_q   <= CNT_W'(WAIT_CYC - 1);
                    noe_q   <= wr_q;
                    nwe_q   <= ~wr_q;
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        noe_q   <= 1'b1;
                        nwe_q   <= 1'b1;
                        ack_q   <= gnt_q;
                        if (!wr_q) rdata_q <= sram_dq_i;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    state_q <= ST_IDLE;
                    nce_q   <= 1'b1;
                    dq_oe_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_nce   = nce_q;
    assign sram_noe   = noe_q;
    assign sram_nwe   = nwe_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (4 ports, 3 wait cycles) with a
// scoreboard of expected completions and per-cycle SRAM protocol checks.
module tb_sram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int W  = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NP-1:0]        req = '0;
    logic [NP-1:0]        wr = '0;
    logic [NP*AW-1:0]     addr = '0;
    logic [NP*DW-1:0]     wdata = '0;
    logic [NP-1:0]        ack;
    logic [DW-1:0]        rdata;
    logic [AW-1:0]        sram_addr;
    logic [DW-1:0]        sram_dq_o;
    logic                 sram_dq_oe;
    logic [DW-1:0]        sram_dq_i = '0;
    logic                 sram_nce;
    logic                 sram_noe;
    logic                 sram_nwe;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NPORTS(NP), .WAIT_CYC(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_nce   (sram_nce),
        .sram_noe   (sram_noe),
        .sram_nwe   (sram_nwe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] r;
    } exp_t;

    exp_t          sb[$];
    int            nchecks = 0;
    int            nerr = 0;
    int            nacks = 0;
    int            tick_n = 0;
    int            nwe_low = 0;
    int            noe_low = 0;
    logic [DW-1:0] rd_last = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then run the protocol monitor and scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        tick_n++;
        if (rst) begin
            nwe_low = 0;
            noe_low = 0;
        end else begin
            if (!sram_nwe) nwe_low++;
            if (!sram_noe) noe_low++;
            chk("strobe_excl", {31'd0, sram_nwe | sram_noe}, 1);
            if (!sram_nwe) chk("oe_during_nwe", {31'd0, sram_dq_oe}, 1);
            if (!sram_nce && sb.size() > 0) begin
                chk("sram_addr", {17'd0, sram_addr}, {17'd0, sb[0].a});
                chk("dq_oe", {31'd0, sram_dq_oe}, {31'd0, sb[0].w});
                if (sb[0].w) chk("dq_o", {24'd0, sram_dq_o}, {24'd0, sb[0].d});
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", {28'd0, ack}, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", {28'd0, ack}, 32'd1 << e.port);
                    chk("rdata", {24'd0, rdata}, {24'd0, e.r});
                    chk("nwe_cycles", nwe_low, e.w ? W : 0);
                    chk("noe_cycles", noe_low, e.w ? 0 : W);
                    nacks++;
                end
                nwe_low = 0;
                noe_low = 0;
            end
        end
    endtask

    task automatic access(input int p, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] dqi, input bit chg);
        exp_t e;
        int   k;
        e.port = p; e.w = w; e.a = a; e.d = d;
        e.r = w ? rd_last : dqi;
        sb.push_back(e);
        @(posedge clk); #1;
        req[p] = 1'b1;
        wr[p] = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
        sram_dq_i = dqi;
        k = 0;
        tick();
        while (ack == '0 && k < 40) begin
            if (chg && k == 2) begin
                addr[p*AW +: AW] = 15'h7FFF;
                wr[p] = ~w;
                wdata[p*DW +: DW] = ~d;
            end
            k++;
            tick();
        end
        chk($sformatf("latency_p%0d", p), k, 2 + W);
        if (!w) rd_last = dqi;
        @(posedge clk); #1;
        req[p] = 1'b0;
        tick();
    endtask

    initial begin
        int   k;
        int   n0;
        int   last_n;
        int   prev;
        exp_t e;

        // Reset state
        tick();
        chk("rst_nce", {31'd0, sram_nce}, 1);
        chk("rst_noe", {31'd0, sram_noe}, 1);
        chk("rst_nwe", {31'd0, sram_nwe}, 1);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 0);
        chk("rst_ack", {28'd0, ack}, 0);
        chk("rst_rdata", {24'd0, rdata}, 0);
        chk("rst_addr", {17'd0, sram_addr}, 0);
        chk("rst_dq_o", {24'd0, sram_dq_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("idle_nce", {31'd0, sram_nce}, 1);
        chk("idle_noe", {31'd0, sram_noe}, 1);
        chk("idle_nwe", {31'd0, sram_nwe}, 1);
        chk("idle_dq_oe", {31'd0, sram_dq_oe}, 0);

        // Basic read, basic write (rdata must hold), address change mid-access
        access(0, 1'b0, 15'h1234, 8'h00, 8'hA5, 1'b0);
        access(1, 1'b1, 15'h0010, 8'h5A, 8'hEE, 1'b0);
        access(0, 1'b0, 15'h0001, 8'h00, 8'h77, 1'b1);

        // All ports requesting continuously
        for (int i = 0; i < 5; i++) begin
`ifdef SRAM_ARB_RR_EN
            e.port = i % NP;
`else
            e.port = 0;
`endif
            e.w = 1'b0;
            e.a = 15'h0100 + 15'(e.port);
            e.d = 8'h00;
            e.r = 8'h3C;
            sb.push_back(e);
        end
        n0 = nacks;
        last_n = nacks;
        prev = -1;
        @(posedge clk); #1;
        sram_dq_i = 8'h3C;
        for (int i = 0; i < NP; i++) begin
            req[i] = 1'b1;
            wr[i] = 1'b0;
            addr[i*AW +: AW] = 15'h0100 + 15'(i);
        end
        k = 0;
        while (nacks < n0 + 5 && k < 100) begin
            tick();
            k++;
            if (nacks != last_n) begin
                if (prev >= 0) chk("b2b_gap", tick_n - prev, 3 + W);
                prev = tick_n;
                last_n = nacks;
            end
        end
        chk("arb_ack_count", nacks - n0, 5);
        rd_last = 8'h3C;
        @(posedge clk); #1;
        req = '0;
        tick();

        // Reset in the middle of a write access
        @(posedge clk); #1;
        req[1] = 1'b1;
        wr[1] = 1'b1;
        addr[1*AW +: AW] = 15'h0222;
        wdata[1*DW +: DW] = 8'hC3;
        k = 0;
        tick();
        while (sram_nwe && k < 20) begin
            k++;
            tick();
        end
        chk("abort_reach_access", {31'd0, sram_nwe}, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_nwe", {31'd0, sram_nwe}, 1);
        chk("abort_dq_oe", {31'd0, sram_dq_oe}, 0);
        chk("abort_nce", {31'd0, sram_nce}, 1);
        chk("abort_ack", {28'd0, ack}, 0);
        chk("abort_rdata", {24'd0, rdata}, 0);
        req = '0;
        rd_last = '0;
        tick();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_abort_ack", {28'd0, ack}, 0);
        end

        // Normal traffic after the abort
        access(2, 1'b1, 15'h0333, 8'h99, 8'h00, 1'b0);
        access(3, 1'b0, 15'h7FFE, 8'h00, 8'h4B, 1'b0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
